// File: rtl/conv_maxpool_2x2.sv
// 2x2 / stride-2 max pooling over a raster-order conv result stream; odd trailing row/col dropped.
// Define MAXPOOL_RELU_EN to clamp negative input words to zero before pooling.
module conv_maxpool_2x2 #(
    parameter int DATA_W = 36,
    parameter int MAP_W  = 13
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     conv_valid,
    input  logic signed [DATA_W-1:0] conv_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] Out_OFM,
    output logic                     out_last,
    output logic                     busy
);
    localparam int POOL_W = MAP_W / 2;
    localparam int CW     = (MAP_W > 2) ? $clog2(MAP_W) : 1;
    localparam int PW     = (POOL_W > 1) ? $clog2(POOL_W) : 1;
    localparam bit MAP_ODD = (MAP_W % 2) == 1;
    localparam logic [CW-1:0] LAST_IDX      = CW'(MAP_W - 1);
    localparam logic [CW-1:0] LAST_POOL_IDX = CW'(2 * POOL_W - 1);

    typedef enum logic [1:0] {IDLE, EVEN, ODD, TAIL} state_t;

    state_t                    state_q, state_d, cls;
    logic [CW-1:0]             col_q, col_d, row_q, row_d;
    logic signed [DATA_W-1:0]  h_q, word, pmax, pool;
    logic signed [DATA_W-1:0]  line_buf_q [POOL_W];
    logic [PW-1:0]             lb_idx;
    logic                      row_end;
    logic                      out_valid_q, out_valid_d;
    logic                      out_last_q, out_last_d;
    logic                      busy_q, busy_d;
    logic signed [DATA_W-1:0]  ofm_q, ofm_d;

    always_comb begin
        word = conv_data;
`ifdef MAXPOOL_RELU_EN
        if (conv_data[DATA_W-1]) word = '0;
`endif
        // IDLE accepts the first word as pixel (0,0) of an even row
        cls     = (state_q == IDLE) ? EVEN : state_q;
        pmax    = (h_q > word) ? h_q : word;
        lb_idx  = PW'(col_q >> 1);
        pool    = (line_buf_q[lb_idx] > pmax) ? line_buf_q[lb_idx] : pmax;
        row_end = (col_q == LAST_IDX);

        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        ofm_d       = ofm_q;
        busy_d      = conv_valid | (state_q != IDLE);

        if (conv_valid) begin
            col_d   = row_end ? '0 : col_q + 1'b1;
            row_d   = row_end ? ((row_q == LAST_IDX) ? '0 : row_q + 1'b1) : row_q;
            state_d = cls;
            if (row_end) begin
                case (cls)
                    EVEN:    state_d = ODD;
                    ODD:     state_d = (row_q != LAST_POOL_IDX) ? EVEN : (MAP_ODD ? TAIL : IDLE);
                    default: state_d = IDLE;
                endcase
            end
            if (cls == ODD && col_q[0]) begin
                out_valid_d = 1'b1;
                ofm_d       = pool;
                out_last_d  = (row_q == LAST_POOL_IDX) && (col_q == LAST_POOL_IDX);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            h_q         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            ofm_q       <= '0;
            busy_q      <= 1'b0;
            for (int i = 0; i < POOL_W; i++) line_buf_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            ofm_q       <= ofm_d;
            busy_q      <= busy_d;
            if (conv_valid && !col_q[0]) h_q <= word;
            if (conv_valid && cls == EVEN && col_q[0]) line_buf_q[lb_idx] <= pmax;
        end
    end

    assign out_valid = out_valid_q;
    assign Out_OFM   = ofm_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_conv_maxpool_2x2.sv
// Scoreboard bench for conv_maxpool_2x2: expected pooled words queued as the completing pixel is driven.
module tb_conv_maxpool_2x2;
    localparam int DATA_W = 36;
    localparam int MAP_W  = 13;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic conv_valid = 1'b0;
    logic signed [DATA_W-1:0] conv_data = '0;
    logic out_valid, out_last, busy;
    logic signed [DATA_W-1:0] Out_OFM;

    conv_maxpool_2x2 #(.DATA_W(DATA_W), .MAP_W(MAP_W)) dut (
        .clk(clk), .rst_n(rst_n), .conv_valid(conv_valid), .conv_data(conv_data),
        .out_valid(out_valid), .Out_OFM(Out_OFM), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [DATA_W-1:0] val;
        logic                     last;
    } exp_t;

    exp_t sbq[$];
    int errors = 0;
    int checks = 0;
    int n_out = 0;
    bit gap_mode = 1'b0;
    logic prev_ov = 1'b0;

    function automatic logic signed [DATA_W-1:0] pix(input int kind, input int r, input int c);
        case (kind)
            0:       return 36'(r * 13 + c);
            1:       return (r == 0 && c == 0) ? -36'sd2 : -36'sd5;
            default: return (r == 12 || c == 12) ? 36'h7FFFFFFFF : 36'd0;
        endcase
    endfunction

    function automatic logic signed [DATA_W-1:0] rl(input logic signed [DATA_W-1:0] x);
`ifdef MAXPOOL_RELU_EN
        return (x < 0) ? 36'sd0 : x;
`else
        return x;
`endif
    endfunction

    function automatic logic signed [DATA_W-1:0] exp_at(input int kind, input int i, input int j);
        logic signed [DATA_W-1:0] m, v;
        m = rl(pix(kind, 2*i, 2*j));
        v = rl(pix(kind, 2*i, 2*j+1));   if (v > m) m = v;
        v = rl(pix(kind, 2*i+1, 2*j));   if (v > m) m = v;
        v = rl(pix(kind, 2*i+1, 2*j+1)); if (v > m) m = v;
        return m;
    endfunction

    // Output monitor: pops the scoreboard on every pooled word
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (out_valid === 1'b1) begin
                n_out++;
                if (gap_mode) begin
                    checks++;
                    if (prev_ov === 1'b1) begin
                        errors++;
                        $display("FAIL gap_rate: out_valid got 1 on consecutive cycles, required 0");
                    end
                end
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got Out_OFM=%0d with empty scoreboard", Out_OFM);
                end else begin
                    e = sbq.pop_front();
                    if (Out_OFM !== e.val || out_last !== e.last) begin
                        errors++;
                        $display("FAIL pooled_word: got %0d last=%b, required %0d last=%b",
                                 Out_OFM, out_last, e.val, e.last);
                    end
                end
            end else begin
                checks++;
                if (out_last !== 1'b0) begin
                    errors++;
                    $display("FAIL out_last_idle: got %b, required 0", out_last);
                end
            end
        end
        prev_ov = out_valid;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int kind, input bit gapped, input int stop_after);
        exp_t e;
        for (int idx = 0; idx < MAP_W * MAP_W; idx++) begin
            int r, c;
            if (idx == stop_after) break;
            r = idx / MAP_W;
            c = idx % MAP_W;
            if (r % 2 == 1 && c % 2 == 1 && r < 12 && c < 12) begin
                e.val  = exp_at(kind, r / 2, c / 2);
                e.last = (r == 11 && c == 11);
                sbq.push_back(e);
            end
            conv_valid = 1'b1;
            conv_data  = pix(kind, r, c);
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_in_frame: got %b at pixel %0d, required 1", busy, idx);
            end
            if (gapped) begin
                conv_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        conv_valid = 1'b0;
    endtask

    task automatic end_of_frames(input string name, input int n0, input int n_exp);
        idle(4);
        checks++;
        if (n_out - n0 !== n_exp) begin
            errors++;
            $display("FAIL %s_count: got %0d outputs, required %0d", name, n_out - n0, n_exp);
        end
        checks++;
        if (sbq.size() !== 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d missing outputs, required 0", name, sbq.size());
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_end: got %b, required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
        checks++; if (Out_OFM !== '0) begin errors++; $display("FAIL reset_ofm: got %0d, required 0", Out_OFM); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b, required 0", out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_ramp();
        int n0 = n_out;
        send_frame(0, 1'b0, -1);
        end_of_frames("ramp", n0, 36);
    endtask

    task automatic test_negatives();
        int n0 = n_out;
        send_frame(1, 1'b0, -1);
        end_of_frames("negatives", n0, 36);
    endtask

    task automatic test_discard_edges();
        int n0 = n_out;
        send_frame(2, 1'b0, -1);
        end_of_frames("discard", n0, 36);
    endtask

    task automatic test_gapped();
        int n0 = n_out;
        gap_mode = 1'b1;
        send_frame(0, 1'b1, -1);
        end_of_frames("gapped", n0, 36);
        gap_mode = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int n0;
        send_frame(0, 1'b0, 50);
        idle(2);
        checks++;
        if (sbq.size() !== 0) begin
            errors++;
            $display("FAIL midreset_partial: got %0d pending, required 0", sbq.size());
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: got busy=%b out_valid=%b, required 0/0", busy, out_valid);
        end
        idle(2);
        rst_n = 1'b1;
        idle(1);
        n0 = n_out;
        send_frame(0, 1'b0, -1);
        end_of_frames("midreset", n0, 36);
    endtask

    task automatic test_back_to_back();
        int n0 = n_out;
        send_frame(0, 1'b0, -1);
        send_frame(1, 1'b0, -1);
        end_of_frames("b2b", n0, 72);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_negatives();
        test_discard_edges();
        test_gapped();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
